// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// loads the IF/ID register, with stall, redirect/flush and misaligned-target flag.
module fetch_stage #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     IMEM_AW  = 6,
  parameter logic [31:0]     NOP_INST = 32'h0000_0033,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        if_id_inst,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               misalign_err,
  output logic [31:0]        fetch_count
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus4;
  logic [31:0]     inst_q, inst_d;
  logic [PC_W-1:0] ipc_q, ipc_d;
  logic [PC_W-1:0] ipc4_q, ipc4_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic [31:0]     cnt_q, cnt_d;

  assign pc_plus4  = pc_q + PC_W'(4);
  assign imem_addr = pc_q[IMEM_AW+1:2];

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      // Redirect beats stall; the word-aligned target is fetched regardless of low bits.
      pc_d    = {redirect_pc[PC_W-1:2], 2'b00};
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      mis_d   = mis_q | (|redirect_pc[1:0]);
    end else if (!stall) begin
      pc_d    = pc_plus4;
      inst_d  = imem_data;
      ipc_d   = pc_q;
      ipc4_d  = pc_plus4;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign if_id_inst     = inst_q;
  assign if_id_pc       = ipc_q;
  assign if_id_pc_plus4 = ipc4_q;
  assign if_id_valid    = valid_q;
  assign misalign_err   = mis_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a combinational memory model holds a small
// ALU program; every step checks the IF/ID outputs against hand-computed values.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_inst, if_id_pc, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, misalign_err;

  logic [31:0] mem [64];
  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_inst     (if_id_inst),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h0000_0033; mem[1]  = 32'h0030_0093;
    mem[2]  = 32'hffc0_a113; mem[3]  = 32'h0050_b193;
    mem[4]  = 32'h00a0_c213; mem[5]  = 32'h0020_e293;
    mem[6]  = 32'h0030_f313; mem[7]  = 32'h0011_1393;
    mem[8]  = 32'h0060_9413; mem[9]  = 32'h0010_d493;
    mem[10] = 32'h4010_d513; mem[11] = 32'h0020_85b3;
    mem[63] = 32'h0000_0013;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk("rst_inst",  if_id_inst, 32'h0000_0033);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc",    if_id_pc, 32'd0);
    chk("rst_pc4",   if_id_pc_plus4, 32'd0);
    chk("rst_cnt",   fetch_count, 32'd0);
    chk("rst_mis",   {31'd0, misalign_err}, 32'd0);
    rst = 1'b0;
    chk("first_addr", {26'd0, imem_addr}, 32'd0);

    // Straight-line fetch
    step();
    chk("f0_inst", if_id_inst, 32'h0000_0033);
    chk("f0_pc", if_id_pc, 32'd0);
    chk("f0_pc4", if_id_pc_plus4, 32'd4);
    chk("f0_valid", {31'd0, if_id_valid}, 32'd1);
    chk("f0_cnt", fetch_count, 32'd1);
    chk("f0_addr", {26'd0, imem_addr}, 32'd1);
    step();
    chk("f1_inst", if_id_inst, 32'h0030_0093);
    chk("f1_pc", if_id_pc, 32'd4);
    chk("f1_cnt", fetch_count, 32'd2);
    step();
    chk("f2_inst", if_id_inst, 32'hffc0_a113);
    chk("f2_pc", if_id_pc, 32'd8);
    chk("f2_cnt", fetch_count, 32'd3);
    chk("f2_addr", {26'd0, imem_addr}, 32'd3);

    // Stall three cycles at pc=12
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_addr", {26'd0, imem_addr}, 32'd3);
      chk("st_inst", if_id_inst, 32'hffc0_a113);
      chk("st_pc", if_id_pc, 32'd8);
      chk("st_cnt", fetch_count, 32'd3);
    end
    stall = 1'b0;
    step();
    chk("rel_inst", if_id_inst, 32'h0050_b193);
    chk("rel_pc", if_id_pc, 32'd12);
    chk("rel_cnt", fetch_count, 32'd4);
    chk("rel_addr", {26'd0, imem_addr}, 32'd4);

    // Redirect to 0x20 while pc=16
    redirect = 1'b1; redirect_pc = 32'h20;
    step();
    chk("rd_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rd_inst", if_id_inst, 32'h0000_0033);
    chk("rd_addr", {26'd0, imem_addr}, 32'd8);
    chk("rd_cnt", fetch_count, 32'd4);
    chk("rd_pc_hold", if_id_pc, 32'd12);
    chk("rd_mis", {31'd0, misalign_err}, 32'd0);
    redirect = 1'b0;
    step();
    chk("rt_inst", if_id_inst, 32'h0060_9413);
    chk("rt_pc", if_id_pc, 32'h20);
    chk("rt_pc4", if_id_pc_plus4, 32'h24);
    chk("rt_valid", {31'd0, if_id_valid}, 32'd1);
    chk("rt_cnt", fetch_count, 32'd5);

    // Redirect and stall together
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h4;
    step();
    chk("rs_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rs_addr", {26'd0, imem_addr}, 32'd1);
    chk("rs_cnt", fetch_count, 32'd5);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk("rs_inst", if_id_inst, 32'h0030_0093);
    chk("rs_pc", if_id_pc, 32'd4);
    chk("rs_cnt2", fetch_count, 32'd6);

    // Misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h0000_000A;
    step();
    chk("ma_mis", {31'd0, misalign_err}, 32'd1);
    chk("ma_addr", {26'd0, imem_addr}, 32'd2);
    chk("ma_valid", {31'd0, if_id_valid}, 32'd0);
    redirect = 1'b0;
    step();
    chk("ma_inst", if_id_inst, 32'hffc0_a113);
    chk("ma_pc", if_id_pc, 32'd8);
    chk("ma_sticky", {31'd0, misalign_err}, 32'd1);
    step();
    chk("ma_inst2", if_id_inst, 32'h0050_b193);
    chk("ma_sticky2", {31'd0, misalign_err}, 32'd1);
    chk("ma_cnt", fetch_count, 32'd8);

    // Reset asserted mid-stall
    stall = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("rs2_mis", {31'd0, misalign_err}, 32'd0);
    chk("rs2_cnt", fetch_count, 32'd0);
    chk("rs2_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rs2_inst", if_id_inst, 32'h0000_0033);
    chk("rs2_pc", if_id_pc, 32'd0);
    chk("rs2_addr", {26'd0, imem_addr}, 32'd0);
    rst = 1'b0; stall = 1'b0;

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("wr_addr", {26'd0, imem_addr}, 32'd63);
    chk("wr_valid", {31'd0, if_id_valid}, 32'd0);
    redirect = 1'b0;
    step();
    chk("wr_addr0", {26'd0, imem_addr}, 32'd0);
    chk("wr_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wr_pc4", if_id_pc_plus4, 32'd0);
    chk("wr_inst", if_id_inst, 32'h0000_0013);
    chk("wr_cnt", fetch_count, 32'd1);
    step();
    chk("wr_next", if_id_inst, 32'h0000_0033);
    chk("wr_next_pc", if_id_pc, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RISC-V core: owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. It sits directly upstream of the instruction memory, which it addresses, and directly upstream of decode, which it feeds. It also handles stall, branch/jump redirect with flush, misaligned-target detection and a retired-fetch counter.

## Interface
- `PC_W`, 32, program-counter width in bits.
- `IMEM_AW`, 6, instruction-memory word-address width (64 words).
- `NOP_INST`, 32'h0000_0033, bubble encoding (`add x0,x0,x0`).
- `RESET_PC`, 32'h0000_0000, PC value after reset.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: hold PC and IF/ID contents (load-use hazard from decode).
- `redirect` in 1: taken branch/jump resolved downstream; flush and refetch.
- `redirect_pc` in PC_W: target byte address for `redirect`.
- `imem_addr` out IMEM_AW: word address to the instruction memory, equal to `pc[IMEM_AW+1:2]`, combinational from `pc`.
- `imem_data` in 32: instruction word returned combinationally by the instruction memory.
- `if_id_inst` out 32: latched instruction.
- `if_id_pc` out PC_W: PC of the latched instruction.
- `if_id_pc_plus4` out PC_W: `if_id_pc + 4`.
- `if_id_valid` out 1: IF/ID holds a real instruction, not a bubble.
- `misalign_err` out 1: sticky flag, set when a redirect target has a nonzero `[1:0]`.
- `fetch_count` out 32: number of valid instructions written into IF/ID.

## Operation
- Internal `pc` register, reset to `RESET_PC`.
- Each edge applies the first matching case, in this priority:
  - `rst`:
    - `pc`←RESET_PC, `if_id_inst`←NOP_INST, `if_id_pc`←0, `if_id_pc_plus4`←0.
    - `if_id_valid`←0, `misalign_err`←0, `fetch_count`←0.
  - `redirect` (overrides `stall`):
    - `pc`←{redirect_pc[PC_W-1:2],2'b00}.
    - IF/ID flushed: `if_id_inst`←NOP_INST, `if_id_valid`←0. `if_id_pc` and `if_id_pc_plus4` are don't-care but stable.
    - If `redirect_pc[1:0]`≠0, `misalign_err`←1.
  - `stall`: `pc` and all IF/ID outputs hold; `fetch_count` holds.
  - Normal:
    - `pc`←pc+4.
    - `if_id_inst`←imem_data, `if_id_pc`←pc, `if_id_pc_plus4`←pc+4, `if_id_valid`←1.
    - `fetch_count`←fetch_count+1.
- Arithmetic:
  - `pc+4` wraps modulo 2^PC_W; 32'hFFFF_FFFC → 0.
  - `fetch_count` wraps modulo 2^32.
- Addressing: PCs above 4·2^IMEM_AW−4 alias into the memory through the truncated `imem_addr`. This is not an error.
- `misalign_err` clears only on `rst`.

## Timing
- Fetch latency: one cycle. `imem_addr` reflects `pc` in the same cycle; the instruction appears on `if_id_inst` after the next edge.
- First cycle after `rst` deasserts: `imem_addr`=0. After the following edge: `if_id_inst`=mem[0], `if_id_pc`=0, `if_id_valid`=1, `pc`=4.
- Redirect penalty:
  - The cycle after `redirect` shows a bubble (`if_id_valid`=0).
  - The target instruction is in IF/ID one edge later, provided `stall` is low.
- Stall held N cycles: `imem_addr` constant for N cycles, and IF/ID is unchanged for those N edges.
- `rst` asserted mid-stall or mid-redirect: reset wins on that edge with no residual state.
- `redirect` and `stall` in the same cycle: redirect is taken and the stall is dropped for that edge.

## Test plan
- Reset then run, memory loaded with the 12-word ALU test program:
  - Consecutive edges give `if_id_inst` = 0000_0033, 0030_0093, ffc0_a113.
  - `if_id_pc` = 0, 4, 8; `if_id_valid`=1.
  - `fetch_count` = 1, 2, 3.
- Stall for 3 cycles while `pc`=12:
  - `imem_addr` stays 3 for all 3 cycles; `if_id_inst` stays ffc0_a113; `fetch_count` stays 3.
  - On release, next value is 0050_b193 with `if_id_pc`=12.
- Redirect to 32'h20 while `pc`=16:
  - Next edge: `if_id_valid`=0, `if_id_inst`=0000_0033, `pc`=32.
  - Following edge: `if_id_inst`=0060_9413, `if_id_pc`=32, `if_id_pc_plus4`=36.
- `redirect` and `stall` together with `redirect_pc`=4:
  - Bubble inserted, `pc`=4; next edge `if_id_inst`=0030_0093.
- Misaligned redirect to 32'h0000_000A:
  - `misalign_err`=1 and stays set; `pc`=8, next fetch is ffc0_a113.
  - `rst` clears `misalign_err` to 0.
- Wrap: `redirect_pc`=32'hFFFF_FFFC:
  - `imem_addr`=63; after one normal edge `pc`=0, `imem_addr`=0, `if_id_pc`=32'hFFFF_FFFC.
